// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: captures decoded controls and operands, supports
// freeze (stall), flush (branch-taken kill), tags bubbles and counts them.
module id_exe_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        hazard_in,
  input  logic        WB_EN_in,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic [3:0]  EXE_CMD_in,
  input  logic [1:0]  Branch_command_in,
  input  logic        ST_or_BNE_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] val1_in,
  input  logic [31:0] val2_in,
  input  logic [31:0] reg2_in,
  input  logic [4:0]  dest_in,
  input  logic [4:0]  src1_in,
  input  logic [4:0]  src2_in,
  output logic        WB_EN_out,
  output logic        MEM_R_EN_out,
  output logic        MEM_W_EN_out,
  output logic [3:0]  EXE_CMD_out,
  output logic [1:0]  Branch_command_out,
  output logic        ST_or_BNE_out,
  output logic [31:0] PC_out,
  output logic [31:0] val1_out,
  output logic [31:0] val2_out,
  output logic [31:0] reg2_out,
  output logic [4:0]  dest_out,
  output logic [4:0]  src1_out,
  output logic [4:0]  src2_out,
  output logic        valid_out,
  output logic [15:0] bubble_count
);

  localparam int unsigned WORD_LEN          = 32;
  localparam int unsigned REG_FILE_ADDR_LEN = 5;
  localparam int unsigned EXE_CMD_LEN       = 4;
  localparam int unsigned CNT_LEN           = 16;
  localparam logic [EXE_CMD_LEN-1:0] EXE_NO_OPERATION = 4'b1111;
  localparam logic [CNT_LEN-1:0]     CNT_MAX          = '1;

  // A bubble is either a flushed slot or a hazard-tagged load; reset is not one.
  logic bubble_c;
  assign bubble_c = !rst && (flush || (!freeze && hazard_in));

  // Pipeline register: rst > flush > freeze > load; reset and flush both
  // install an all-zero no-op entry so stale or X inputs never leak through.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      WB_EN_out          <= 1'b0;
      MEM_R_EN_out       <= 1'b0;
      MEM_W_EN_out       <= 1'b0;
      EXE_CMD_out        <= EXE_NO_OPERATION;
      Branch_command_out <= 2'b00;
      ST_or_BNE_out      <= 1'b0;
      PC_out             <= WORD_LEN'(0);
      val1_out           <= WORD_LEN'(0);
      val2_out           <= WORD_LEN'(0);
      reg2_out           <= WORD_LEN'(0);
      dest_out           <= REG_FILE_ADDR_LEN'(0);
      src1_out           <= REG_FILE_ADDR_LEN'(0);
      src2_out           <= REG_FILE_ADDR_LEN'(0);
      valid_out          <= 1'b0;
    end else if (!freeze) begin
      WB_EN_out          <= WB_EN_in;
      MEM_R_EN_out       <= MEM_R_EN_in;
      MEM_W_EN_out       <= MEM_W_EN_in;
      EXE_CMD_out        <= EXE_CMD_in;
      Branch_command_out <= Branch_command_in;
      ST_or_BNE_out      <= ST_or_BNE_in;
      PC_out             <= PC_in;
      val1_out           <= val1_in;
      val2_out           <= val2_in;
      reg2_out           <= reg2_in;
      dest_out           <= dest_in;
      src1_out           <= src1_in;
      src2_out           <= src2_in;
      valid_out          <= !hazard_in;
    end
  end

  // Saturating bubble counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count <= CNT_LEN'(0);
    end else if (bubble_c && (bubble_count != CNT_MAX)) begin
      bubble_count <= bubble_count + CNT_LEN'(1);
    end
  end

endmodule

// File: tb/tb_id_exe_reg.sv
// Directed bench for the ID/EXE pipeline register.
module tb_id_exe_reg;

  localparam logic [3:0] EXE_NOP = 4'b1111;
  localparam logic [3:0] EXE_ADD = 4'b0000;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, hazard_in;
  logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, ST_or_BNE_in;
  logic [3:0]  EXE_CMD_in;
  logic [1:0]  Branch_command_in;
  logic [31:0] PC_in, val1_in, val2_in, reg2_in;
  logic [4:0]  dest_in, src1_in, src2_in;
  logic        WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, ST_or_BNE_out;
  logic [3:0]  EXE_CMD_out;
  logic [1:0]  Branch_command_out;
  logic [31:0] PC_out, val1_out, val2_out, reg2_out;
  logic [4:0]  dest_out, src1_out, src2_out;
  logic        valid_out;
  logic [15:0] bubble_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_exe_reg dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard_in(hazard_in),
    .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
    .EXE_CMD_in(EXE_CMD_in), .Branch_command_in(Branch_command_in),
    .ST_or_BNE_in(ST_or_BNE_in), .PC_in(PC_in), .val1_in(val1_in),
    .val2_in(val2_in), .reg2_in(reg2_in), .dest_in(dest_in), .src1_in(src1_in),
    .src2_in(src2_in),
    .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out),
    .EXE_CMD_out(EXE_CMD_out), .Branch_command_out(Branch_command_out),
    .ST_or_BNE_out(ST_or_BNE_out), .PC_out(PC_out), .val1_out(val1_out),
    .val2_out(val2_out), .reg2_out(reg2_out), .dest_out(dest_out),
    .src1_out(src1_out), .src2_out(src2_out), .valid_out(valid_out),
    .bubble_count(bubble_count)
  );

  // Count a comparison and report it if it differs.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a complete set of decode inputs.
  task automatic drive(input logic wb, input logic mr, input logic mw, input logic [3:0] cmd,
                       input logic [1:0] br, input logic sb, input logic [31:0] pc,
                       input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] r2,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    WB_EN_in = wb; MEM_R_EN_in = mr; MEM_W_EN_in = mw; EXE_CMD_in = cmd;
    Branch_command_in = br; ST_or_BNE_in = sb; PC_in = pc; val1_in = v1;
    val2_in = v2; reg2_in = r2; dest_in = d; src1_in = s1; src2_in = s2;
  endtask

  // Verify the all-zero no-op entry left by reset or flush.
  task automatic check_killed(input string tag);
    check({tag, ".wb"},    32'(WB_EN_out), 32'd0);
    check({tag, ".mr"},    32'(MEM_R_EN_out), 32'd0);
    check({tag, ".mw"},    32'(MEM_W_EN_out), 32'd0);
    check({tag, ".cmd"},   32'(EXE_CMD_out), 32'(EXE_NOP));
    check({tag, ".br"},    32'(Branch_command_out), 32'd0);
    check({tag, ".sb"},    32'(ST_or_BNE_out), 32'd0);
    check({tag, ".pc"},    PC_out, 32'd0);
    check({tag, ".val1"},  val1_out, 32'd0);
    check({tag, ".val2"},  val2_out, 32'd0);
    check({tag, ".reg2"},  reg2_out, 32'd0);
    check({tag, ".dest"},  32'(dest_out), 32'd0);
    check({tag, ".valid"}, 32'(valid_out), 32'd0);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; hazard_in = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 4'h5, 2'b11, 1'b1, 32'hAAAA, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3);
    step();
    check_killed("reset");
    check("reset.bubbles", 32'(bubble_count), 32'd0);

    // Plain ADD load
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, EXE_ADD, 2'b00, 1'b0, 32'h4, 32'h10, 32'h20, 32'h0, 5'd3, 5'd1, 5'd2);
    step();
    check("add.wb",      32'(WB_EN_out), 32'd1);
    check("add.cmd",     32'(EXE_CMD_out), 32'(EXE_ADD));
    check("add.dest",    32'(dest_out), 32'd3);
    check("add.val1",    val1_out, 32'h10);
    check("add.val2",    val2_out, 32'h20);
    check("add.src2",    32'(src2_out), 32'd2);
    check("add.valid",   32'(valid_out), 32'd1);
    check("add.bubbles", 32'(bubble_count), 32'd0);

    // Store load, then hold through three frozen cycles with changing inputs
    drive(1'b0, 1'b0, 1'b1, EXE_ADD, 2'b00, 1'b1, 32'h8, 32'h100, 32'h4, 32'hBEEF, 5'd0, 5'd4, 5'd5);
    step();
    check("st.mw", 32'(MEM_W_EN_out), 32'd1);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hazard_in = (i == 1);
      drive(1'b1, 1'b1, 1'b0, 4'(i), 2'(i), 1'b0, 32'(i + 100), 32'(i), 32'(i), 32'(i),
            5'(i + 7), 5'(i), 5'(i));
      step();
      check("frz.mw",      32'(MEM_W_EN_out), 32'd1);
      check("frz.wb",      32'(WB_EN_out), 32'd0);
      check("frz.pc",      PC_out, 32'h8);
      check("frz.reg2",    reg2_out, 32'hBEEF);
      check("frz.valid",   32'(valid_out), 32'd1);
      check("frz.bubbles", 32'(bubble_count), 32'd0);
    end

    // Valid ADD entry, then flush and freeze together: flush wins
    freeze = 1'b0; hazard_in = 1'b0;
    drive(1'b1, 1'b0, 1'b0, EXE_ADD, 2'b00, 1'b0, 32'hC, 32'h1, 32'h2, 32'h0, 5'd9, 5'd1, 5'd2);
    step();
    check("pre_flush.wb", 32'(WB_EN_out), 32'd1);
    flush = 1'b1; freeze = 1'b1;
    step();
    check_killed("flush_frz");
    check("flush_frz.bubbles", 32'(bubble_count), 32'd1);

    // Two hazard bubbles with controller-zeroed controls
    flush = 1'b0; freeze = 1'b0; hazard_in = 1'b1;
    drive(1'b0, 1'b0, 1'b0, EXE_NOP, 2'b00, 1'b0, 32'h20, 32'h5, 32'h6, 32'h0, 5'd0, 5'd7, 5'd8);
    step();
    check("haz1.valid",   32'(valid_out), 32'd0);
    check("haz1.pc",      PC_out, 32'h20);
    check("haz1.src1",    32'(src1_out), 32'd7);
    check("haz1.bubbles", 32'(bubble_count), 32'd2);
    PC_in = 32'h24;
    step();
    check("haz2.valid",   32'(valid_out), 32'd0);
    check("haz2.pc",      PC_out, 32'h24);
    check("haz2.bubbles", 32'(bubble_count), 32'd3);

    // Reset while frozen on a valid entry
    hazard_in = 1'b0;
    drive(1'b1, 1'b1, 1'b0, EXE_ADD, 2'b01, 1'b1, 32'h30, 32'h7, 32'h8, 32'h9, 5'd6, 5'd1, 5'd2);
    step();
    check("pre_rst.valid", 32'(valid_out), 32'd1);
    rst = 1'b1; freeze = 1'b1;
    step();
    check_killed("rst_frz");
    check("rst_frz.bubbles", 32'(bubble_count), 32'd0);
    rst = 1'b0; freeze = 1'b0;
    step();
    check("post_rst.valid", 32'(valid_out), 32'd1);
    check("post_rst.pc",    PC_out, 32'h30);
    check("post_rst.bubbles", 32'(bubble_count), 32'd0);

    // Saturation of the bubble counter
    flush = 1'b1;
    for (int i = 0; i < 65534; i++) step();
    check("sat.fffe", 32'(bubble_count), 32'h0000FFFE);
    step();
    check("sat.ffff", 32'(bubble_count), 32'h0000FFFF);
    step();
    check("sat.hold1", 32'(bubble_count), 32'h0000FFFF);
    step();
    check("sat.hold2", 32'(bubble_count), 32'h0000FFFF);
    check_killed("sat");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
